// File: rtl/starforce_rom_pkg.sv
// starforce_rom_pkg: Star Force ROM region map, load-FSM states and queued ROM write entry type.
package starforce_rom_pkg;
  typedef enum logic [2:0] {REG_CPU, REG_SND, REG_FG, REG_BG1, REG_BG2, REG_BG3, REG_SPR} rom_region_e;
  typedef enum logic [1:0] {ST_RUN, ST_LOAD, ST_DRAIN, ST_HOLD} load_st_e;
  typedef struct packed {
    rom_region_e region;
    logic [14:0] offset;
    logic [7:0]  data;
  } rom_wr_t;
  localparam int NUM_REGIONS = 7;
  localparam logic [24:0] REGION_BASE [NUM_REGIONS] = '{25'h00000, 25'h08000, 25'h0A000, 25'h0D000,
                                                         25'h10000, 25'h13000, 25'h16000};
  localparam logic [24:0] REGION_SIZE [NUM_REGIONS] = '{25'h08000, 25'h02000, 25'h03000, 25'h03000,
                                                         25'h03000, 25'h03000, 25'h06000};
  localparam logic [24:0] ROM_END = REGION_BASE[NUM_REGIONS-1] + REGION_SIZE[NUM_REGIONS-1];
  localparam logic [7:0] ROM_IDX = 8'd0;
  localparam logic [7:0] DIP_IDX = 8'd254;
  function automatic rom_wr_t rom_decode(input logic [24:0] addr, input logic [7:0] data);
    rom_wr_t e;
    e.region = REG_CPU;
    e.offset = addr[14:0];
    e.data   = data;
    for (int i = 1; i < NUM_REGIONS; i++)
      if (addr >= REGION_BASE[i]) begin
        e.region = rom_region_e'(3'(i));
        e.offset = 15'(addr - REGION_BASE[i]);
      end
    return e;
  endfunction
endpackage

// File: rtl/rom_load_fifo.sv
// rom_load_fifo: power-of-two FIFO of ROM write entries, also exposing the entry behind the head.
module rom_load_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 26
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [W-1:0]             dout_nxt,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic wr_en, rd_en;
  assign full     = cnt_q[AW];
  assign empty    = cnt_q == '0;
  assign wr_en    = push & ~full;
  assign rd_en    = pop & ~empty;
  assign dout     = mem_q[rd_q];
  assign dout_nxt = mem_q[rd_q + AW'(1)];
  assign count    = cnt_q;
  always_ff @(posedge clk_sys)
    if (wr_en) mem_q[wr_q] <= din;
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(wr_en);
      rd_q  <= rd_q + AW'(rd_en);
      cnt_q <= cnt_q + CW'(wr_en) - CW'(rd_en);
    end
endmodule

// File: rtl/rom_load_sched.sv
// rom_load_sched: ioctl download to Star Force ROM write sequencer with DIP capture and core reset hold; ROM_CHECKSUM_EN drives rom_sum with the sum of acked bytes.
module rom_load_sched
  import starforce_rom_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 4,
  parameter int          RESET_HOLD  = 1024,
  parameter logic [15:0] DIP_DEFAULT = 16'hFFFF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        rom_wr_req,
  input  logic        rom_wr_ack,
  output logic [2:0]  rom_region,
  output logic [14:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        core_reset,
  output logic        load_done,
  output logic [1:0]  load_err,
  output logic [15:0] dip_sw,
  output logic [15:0] rom_sum
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int HW = $clog2(RESET_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);
  load_st_e st_q, st_d;
  logic [HW-1:0] cnt_q, cnt_d;
  logic dl_q, req_q, req_d, wait_q, done_q;
  logic [1:0] err_q, err_d;
  logic [15:0] dip_q, dip_d;
  rom_wr_t ent, head, head_nxt, fld_q, fld_d;
  logic full, empty, rom_sel, dip_sel, push, pop, rise, more;
  logic [CW-1:0] count, count_nxt;
  assign rom_sel = ioctl_download & ioctl_wr & (ioctl_index == ROM_IDX);
  assign dip_sel = ioctl_download & ioctl_wr & (ioctl_index == DIP_IDX) & (ioctl_addr[24:3] == '0);
  assign push    = rom_sel & (ioctl_addr < ROM_END);
  assign pop     = req_q & rom_wr_ack;
  assign rise    = ioctl_download & (ioctl_index == ROM_IDX) & ~dl_q;
  assign more    = count > CW'(1);
  assign ent     = rom_decode(ioctl_addr, ioctl_dout);
  rom_load_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(rom_wr_t))) u_fifo (
    .clk_sys, .reset_n, .push, .din(ent), .pop,
    .dout(head), .dout_nxt(head_nxt), .full, .empty, .count
  );
  always_comb begin
    count_nxt = count + CW'(push & ~full) - CW'(pop);
    req_d     = req_q ? (~rom_wr_ack | more) : ~empty;
    fld_d     = (~req_q & ~empty) ? head : (pop & more) ? head_nxt : fld_q;
    err_d     = (rise ? 2'b00 : err_q) | {push & full, rom_sel & ~push};
    dip_d     = ~dip_sel ? dip_q :
                (ioctl_addr[2:0] == 3'd0) ? {ioctl_dout, dip_q[7:0]} :
                (ioctl_addr[2:0] == 3'd1) ? {dip_q[15:8], ioctl_dout} : dip_q;
    st_d      = st_q;
    cnt_d     = cnt_q;
    if (rise) begin
      st_d  = ST_LOAD;
      cnt_d = '0;
    end else begin
      case (st_q)
        ST_LOAD:  st_d = ioctl_download ? ST_LOAD : ST_DRAIN;
        ST_DRAIN: st_d = (empty & ~req_q) ? ST_HOLD : ST_DRAIN;
        ST_HOLD: begin
          cnt_d = cnt_q + HW'(1);
          st_d  = (cnt_q == HOLD_LAST) ? ST_RUN : ST_HOLD;
        end
        default:  st_d = st_q;
      endcase
    end
  end
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      st_q   <= ST_HOLD;
      cnt_q  <= '0;
      dl_q   <= 1'b0;
      req_q  <= 1'b0;
      wait_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= '0;
      dip_q  <= DIP_DEFAULT;
      fld_q  <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      dl_q   <= ioctl_download & (ioctl_index == ROM_IDX);
      req_q  <= req_d;
      wait_q <= count_nxt >= CW'(FIFO_DEPTH - 1);
      done_q <= done_q | (st_q != ST_RUN && st_d == ST_RUN);
      err_q  <= err_d;
      dip_q  <= dip_d;
      fld_q  <= fld_d;
    end
`ifdef ROM_CHECKSUM_EN
  logic [15:0] sum_q;
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) sum_q <= '0;
    else if (rise) sum_q <= '0;
    else if (pop && st_q != ST_RUN) sum_q <= sum_q + {8'd0, fld_q.data};
  assign rom_sum = sum_q;
`else
  assign rom_sum = '0;
`endif
  assign ioctl_wait = wait_q;
  assign rom_wr_req = req_q;
  assign rom_region = fld_q.region;
  assign rom_addr   = fld_q.offset;
  assign rom_data   = fld_q.data;
  assign core_reset = st_q != ST_RUN;
  assign load_done  = done_q;
  assign load_err   = err_q;
  assign dip_sw     = dip_q;
endmodule

// File: tb/tb_rom_load_sched.sv
// tb_rom_load_sched: directed and randomized download checks against a region-table / byte-list reference model.
module tb_rom_load_sched;
  localparam int RESET_HOLD = 1024;
  logic clk_sys = 1'b0, reset_n = 1'b1, ioctl_download = 1'b0, ioctl_wr = 1'b0, rom_wr_ack = 1'b0;
  logic [7:0] ioctl_index = 8'd0, ioctl_dout = 8'd0;
  logic [24:0] ioctl_addr = 25'd0;
  logic ioctl_wait, rom_wr_req, core_reset, load_done;
  logic [2:0] rom_region;
  logic [14:0] rom_addr;
  logic [7:0] rom_data;
  logic [1:0] load_err;
  logic [15:0] dip_sw, rom_sum;
  int vecs = 0, errs = 0, got = 0;
  logic [25:0] sb [$];
  logic auto_ack = 1'b0, ack_force = 1'b0, pend = 1'b0;
  logic [15:0] exp_sum = 16'd0;
  logic [1:0] exp_err = 2'b00;
  logic [7:0] sw0 = 8'hFF, sw1 = 8'hFF;
  int sizes [7] = '{32768, 8192, 12288, 12288, 12288, 12288, 24576};

  always #5 clk_sys = ~clk_sys;

  rom_load_sched dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .rom_wr_req(rom_wr_req), .rom_wr_ack(rom_wr_ack), .rom_region(rom_region), .rom_addr(rom_addr),
    .rom_data(rom_data), .core_reset(core_reset), .load_done(load_done), .load_err(load_err),
    .dip_sw(dip_sw), .rom_sum(rom_sum)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [25:0] ref_map(input int a, input logic [7:0] d);
    int base = 0;
    for (int i = 0; i < 7; i++) begin
      if (a < base + sizes[i]) return {3'(i), 15'(a - base), d};
      base += sizes[i];
    end
    return '0;
  endfunction

  task automatic rom_byte(input int a, input logic [7:0] d);
    int lim = 0;
    for (int i = 0; i < 7; i++) lim += sizes[i];
    if (a >= lim) exp_err[0] = 1'b1;
    else sb.push_back(ref_map(a, d));
    ioctl_addr = 25'(a);
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
  endtask

  task automatic dip_byte(input logic [24:0] a, input logic [7:0] d);
    if (a == 25'd0) sw0 = d;
    else if (a == 25'd1) sw1 = d;
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    check("dip_sw", 32'(dip_sw), 32'({sw0, sw1}));
    check("dip_core_reset", 32'(core_reset), 0);
  endtask

  task automatic hold_check(input string tag);
    int n = 0;
    logic seen = 1'b0;
    while (core_reset && n < 1100) begin
      @(negedge clk_sys);
      n++;
      seen |= rom_wr_req;
    end
    check({tag, "_hold_cycles"}, n, RESET_HOLD);
    check({tag, "_no_req"}, 32'(seen), 0);
    check({tag, "_load_done"}, 32'(load_done), 1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sb.size() > 0 || rom_wr_req) && n < 400) begin
      @(negedge clk_sys);
      n++;
    end
    check({tag, "_drained"}, sb.size(), 0);
  endtask

  task automatic wait_run(input string tag);
    int n = 0;
    while (core_reset && n < 3000) begin
      @(negedge clk_sys);
      n++;
    end
    check({tag, "_core_reset"}, 32'(core_reset), 0);
    check({tag, "_load_done"}, 32'(load_done), 1);
  endtask

  task automatic sum_check(input string tag);
`ifdef ROM_CHECKSUM_EN
    check({tag, "_rom_sum"}, 32'(rom_sum), 32'(exp_sum));
`else
    check({tag, "_rom_sum"}, 32'(rom_sum), 0);
`endif
  endtask

  always @(negedge clk_sys) begin
    if (pend && sb.size() > 0) begin
      got++;
      exp_sum += 16'(sb[0][7:0]);
      void'(sb.pop_front());
    end
    pend = 1'b0;
    if (rom_wr_req) begin
      check("req_expected", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        check("rom_region", 32'(rom_region), 32'(sb[0][25:23]));
        check("rom_addr", 32'(rom_addr), 32'(sb[0][22:8]));
        check("rom_data", 32'(rom_data), 32'(sb[0][7:0]));
      end
    end
    rom_wr_ack = auto_ack ? (rom_wr_req & 1'($urandom_range(0, 1))) : ack_force;
    pend = rom_wr_req & rom_wr_ack;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, got0, a;
    logic [7:0] d;
    #1 reset_n = 1'b0;
    #3;
    check("rst_wait", 32'(ioctl_wait), 0);
    check("rst_req", 32'(rom_wr_req), 0);
    check("rst_region", 32'(rom_region), 0);
    check("rst_addr", 32'(rom_addr), 0);
    check("rst_data", 32'(rom_data), 0);
    check("rst_core_reset", 32'(core_reset), 1);
    check("rst_load_done", 32'(load_done), 0);
    check("rst_load_err", 32'(load_err), 0);
    check("rst_dip_sw", 32'(dip_sw), 32'hFFFF);
    check("rst_rom_sum", 32'(rom_sum), 0);
    ack_force = 1'b1;
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    hold_check("por");

    ack_force = 1'b0;
    auto_ack = 1'b1;
    exp_err = 2'b00;
    exp_sum = 16'd0;
    ioctl_index = 8'd0;
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    check("ld1_core_reset", 32'(core_reset), 1);
    check("ld1_err_clear", 32'(load_err), 0);
    check("ld1_done_sticky", 32'(load_done), 1);
    rom_byte('h0A005, 8'h5A);
    repeat (4) @(negedge clk_sys);
    check("fg_byte_err", 32'(load_err), 0);
    for (int k = 0; k < 40; k++) begin
      n = 0;
      while (ioctl_wait && n < 50) begin
        @(negedge clk_sys);
        n++;
      end
      check("wait_release", 32'(ioctl_wait), 0);
      a = int'($urandom_range(0, 'h1C3FF));
      d = 8'($urandom);
      rom_byte(a, d);
      if ($urandom_range(0, 3) == 0) @(negedge clk_sys);
    end
    check("ld1_err", 32'(load_err), 32'(exp_err));
    ioctl_download = 1'b0;
    drain("ld1");
    wait_run("ld1");
    sum_check("ld1");

    auto_ack = 1'b0;
    exp_err = 2'b00;
    exp_sum = 16'd0;
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    for (int k = 0; k < 8; k++) begin
      d = 8'($urandom);
      ioctl_addr = 25'('h16000 + k);
      ioctl_dout = d;
      ioctl_wr = 1'b1;
      if (k < 4) sb.push_back(ref_map('h16000 + k, d));
      @(negedge clk_sys);
      check("ovf_wait", 32'(ioctl_wait), 32'(k >= 2));
      check("ovf_err", 32'(load_err), (k >= 4) ? 2 : 0);
    end
    ioctl_wr = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("ovf_req_held", 32'(rom_wr_req), 1);
    check("ovf_wait_held", 32'(ioctl_wait), 1);
    got0 = got;
    auto_ack = 1'b1;
    drain("ovf");
    repeat (4) @(negedge clk_sys);
    check("ovf_writes", got - got0, 4);
    check("ovf_wait_low", 32'(ioctl_wait), 0);
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    check("ovf_err_sticky", 32'(load_err), 2);
    wait_run("ovf");
    sum_check("ovf");

    ioctl_download = 1'b1;
    @(negedge clk_sys);
    check("oor_err_cleared", 32'(load_err), 0);
    exp_err = 2'b00;
    rom_byte('h1C000, 8'hA5);
    check("oor_err", 32'(load_err), 32'(exp_err));
    repeat (3) @(negedge clk_sys);
    check("oor_no_req", 32'(rom_wr_req), 0);
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    check("oor_err_next_dl", 32'(load_err), 0);
    ioctl_download = 1'b0;
    wait_run("oor");

    ioctl_index = 8'd254;
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    check("dip_dl_core_reset", 32'(core_reset), 0);
    dip_byte(25'd0, 8'h12);
    dip_byte(25'd1, 8'h34);
    dip_byte(25'd2, 8'h99);
    dip_byte(25'd8, 8'h77);
    dip_byte(25'd9, 8'h66);
    for (int k = 0; k < 6; k++) begin
      a = int'($urandom_range(0, 3));
      dip_byte((a == 3) ? 25'd8 : 25'(a), 8'($urandom));
    end
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    check("dip_end_core_reset", 32'(core_reset), 0);
    check("dip_no_req", 32'(rom_wr_req), 0);

    auto_ack = 1'b0;
    ioctl_index = 8'd0;
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    rom_byte('h00010, 8'h11);
    rom_byte('h08020, 8'h22);
    @(negedge clk_sys);
    check("mid_req_before", 32'(rom_wr_req), 1);
    #2 reset_n = 1'b0;
    ioctl_download = 1'b0;
    #1;
    check("mid_req_async", 32'(rom_wr_req), 0);
    check("mid_wait", 32'(ioctl_wait), 0);
    check("mid_core_reset", 32'(core_reset), 1);
    check("mid_load_done", 32'(load_done), 0);
    check("mid_load_err", 32'(load_err), 0);
    sb.delete();
    @(negedge clk_sys);
    reset_n = 1'b1;
    hold_check("mid");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
